// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: vending core; in: clk, rst_n, coin_pulse, sel_next, cancel; out: item_idx, price, credit, change, state_o, busy, vend/refund/reject pulses
module vend_ctrl_param #(
  parameter int NUM_ITEMS = 4,
  parameter int NUM_COINS = 2,
  parameter int VAL_W = 7,
  parameter logic [NUM_ITEMS*VAL_W-1:0] PRICE_TABLE = {7'd30, 7'd24, 7'd15, 7'd5},
  parameter logic [NUM_COINS*VAL_W-1:0] COIN_TABLE = {7'd10, 7'd5},
  parameter int HOLD_CYC = 100_000_000,
  parameter int TIMEOUT_CYC = 1_500_000_000,
  localparam int IW = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coin_pulse,
  input  logic                 sel_next,
  input  logic                 cancel,
  output logic [IW-1:0]        item_idx,
  output logic [VAL_W-1:0]     price,
  output logic [VAL_W-1:0]     credit,
  output logic [VAL_W-1:0]     change,
  output logic [1:0]           state_o,
  output logic                 busy,
  output logic                 vend_pulse,
  output logic                 refund_pulse,
  output logic                 reject_pulse
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;
  state_t st;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] next_idx;
  logic [VAL_W-1:0] next_price;
  logic [VAL_W-1:0] coin_val;
  logic [VAL_W:0] sum;
  logic coin_any, coin_multi, coin_ok, vend_due, idle_tick, timed_out, hold_done;
  always_comb begin
    coin_val = '0;
    for (int j = NUM_COINS - 1; j >= 0; j--) coin_val = coin_pulse[j] ? COIN_TABLE[j*VAL_W +: VAL_W] : coin_val;
    next_idx = item_idx == IW'(NUM_ITEMS - 1) ? '0 : item_idx + 1'b1;
    next_price = PRICE_TABLE[VAL_W-1:0];
    for (int i = 0; i < NUM_ITEMS; i++) next_price = next_idx == IW'(i) ? PRICE_TABLE[i*VAL_W +: VAL_W] : next_price;
  end
  assign sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_any = |coin_pulse;
  assign coin_multi = |(coin_pulse & (coin_pulse - NUM_COINS'(1)));
  assign coin_ok = coin_any && !sum[VAL_W];
  assign vend_due = st == CREDIT && credit >= price;
  assign idle_tick = TIMEOUT_CYC > 0 && st == CREDIT && !vend_due && !cancel && !coin_ok && !(sel_next && !coin_any);
  assign timed_out = idle_tick && tcnt == TW'(TO_LAST);
  assign hold_done = hcnt == HW'(HOLD_CYC - 1);
  assign state_o = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      item_idx <= '0;
      price <= PRICE_TABLE[VAL_W-1:0];
      credit <= '0;
      change <= '0;
      busy <= 1'b0;
      vend_pulse <= 1'b0;
      refund_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      hcnt <= '0;
      tcnt <= '0;
    end else begin
      vend_pulse <= 1'b0;
      refund_pulse <= 1'b0;
      reject_pulse <= coin_any;
      tcnt <= idle_tick ? tcnt + 1'b1 : '0;
      if (busy) begin
        hcnt <= hcnt + 1'b1;
        if (hold_done) begin
          st <= IDLE;
          busy <= 1'b0;
          credit <= '0;
          change <= '0;
          hcnt <= '0;
        end
      end else if (vend_due) begin
        st <= VEND;
        busy <= 1'b1;
        vend_pulse <= 1'b1;
        change <= credit - price;
      end else if (cancel) begin
        if (st == CREDIT) begin
          st <= REFUND;
          busy <= 1'b1;
          refund_pulse <= 1'b1;
          change <= credit;
        end
      end else if (coin_any) begin
        reject_pulse <= coin_multi | sum[VAL_W];
        if (!sum[VAL_W]) begin
          st <= CREDIT;
          credit <= sum[VAL_W-1:0];
        end
      end else if (sel_next) begin
        item_idx <= next_idx;
        price <= next_price;
      end
      if (timed_out) begin
        st <= REFUND;
        busy <= 1'b1;
        refund_pulse <= 1'b1;
        change <= credit;
        tcnt <= '0;
      end
    end
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: vector table, corner sequences and random stimulus against a behavioural model
module tb_vend_ctrl_param;
  localparam int HOLD = 20, TMO = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] coin_pulse;
  logic sel_next, cancel;
  logic [1:0] item_idx, state_o;
  logic [6:0] price, credit, change;
  logic busy, vend_pulse, refund_pulse, reject_pulse;
  logic [1:0] c2, st2;
  logic s2, x2, idx2, busy2, vp2, rp2, rj2;
  logic [6:0] price2, credit2, change2;
  int errs = 0, checks = 0;
  int ptab[4] = '{5, 15, 24, 30};
  int m_mode, m_idx, m_cred, m_chg, m_hold, m_quiet;
  bit m_vp, m_rp, m_rj;
  always #5 clk = ~clk;
  vend_ctrl_param #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_pulse(coin_pulse), .sel_next(sel_next), .cancel(cancel),
    .item_idx(item_idx), .price(price), .credit(credit), .change(change), .state_o(state_o),
    .busy(busy), .vend_pulse(vend_pulse), .refund_pulse(refund_pulse), .reject_pulse(reject_pulse));
  vend_ctrl_param #(.NUM_ITEMS(2), .PRICE_TABLE({7'd10, 7'd127}), .HOLD_CYC(4), .TIMEOUT_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .coin_pulse(c2), .sel_next(s2), .cancel(x2),
    .item_idx(idx2), .price(price2), .credit(credit2), .change(change2), .state_o(st2),
    .busy(busy2), .vend_pulse(vp2), .refund_pulse(rp2), .reject_pulse(rj2));
  typedef struct {
    logic [1:0] c;
    logic s, x;
    int n, st, cr, ch, idx;
    logic [2:0] p;
  } vec_t;
  vec_t tbl[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic m_reset();
    m_mode = 0; m_idx = 0; m_cred = 0; m_chg = 0; m_hold = 0; m_quiet = 0;
    m_vp = 0; m_rp = 0; m_rj = 0;
  endtask
  task automatic enter_hold(input int mode, input int chg);
    m_mode = mode; m_hold = HOLD; m_chg = chg;
  endtask
  task automatic model_step(input logic [1:0] c, input logic s, input logic x);
    bit acc, was_credit;
    int v;
    m_vp = 0; m_rp = 0; m_rj = 0; acc = 0;
    was_credit = (m_mode == 1);
    if (m_mode >= 2) begin
      m_rj = (c != 0);
      m_hold--;
      if (m_hold == 0) begin m_mode = 0; m_cred = 0; m_chg = 0; end
    end else if (was_credit && m_cred >= ptab[m_idx]) begin
      enter_hold(2, m_cred - ptab[m_idx]);
      m_vp = 1; m_rj = (c != 0);
    end else begin
      if (x) begin
        acc = 1; m_rj = (c != 0);
        if (was_credit) begin enter_hold(3, m_cred); m_rp = 1; end
      end else if (c != 0) begin
        v = c[0] ? 5 : 10;
        m_rj = (c == 2'b11);
        if (m_cred + v > 127) m_rj = 1;
        else begin m_cred += v; m_mode = 1; acc = 1; end
      end else if (s) begin
        m_idx = (m_idx + 1) % 4; acc = 1;
      end
      if (!was_credit || acc) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == TMO) begin enter_hold(3, m_cred); m_rp = 1; m_quiet = 0; end
      end
    end
  endtask
  task automatic check_model();
    chk("state", state_o, m_mode);
    chk("item_idx", item_idx, m_idx);
    chk("price", price, ptab[m_idx]);
    chk("credit", credit, m_cred);
    chk("change", change, m_chg);
    chk("busy", busy, m_mode >= 2);
    chk("vend_pulse", vend_pulse, m_vp);
    chk("refund_pulse", refund_pulse, m_rp);
    chk("reject_pulse", reject_pulse, m_rj);
  endtask
  task automatic cyc(input logic [1:0] c, input logic s, input logic x);
    coin_pulse = c; sel_next = s; cancel = x;
    @(posedge clk);
    model_step(c, s, x);
    #1 check_model();
  endtask
  task automatic drive2(input logic [1:0] c, input logic s, input logic x);
    c2 = c; s2 = s; x2 = x;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    coin_pulse = 0; sel_next = 0; cancel = 0; c2 = 0; s2 = 0; x2 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_reset();
    check_model();
  endtask
  initial begin
    int got;
    tbl[0]  = '{2'b01, 0, 0, 1,  1, 5,  0, 0, 3'b000};
    tbl[1]  = '{2'b00, 0, 0, 1,  2, 5,  0, 0, 3'b100};
    tbl[2]  = '{2'b00, 0, 0, 19, 2, 5,  0, 0, 3'b000};
    tbl[3]  = '{2'b00, 0, 0, 1,  0, 0,  0, 0, 3'b000};
    tbl[4]  = '{2'b00, 1, 0, 1,  0, 0,  0, 1, 3'b000};
    tbl[5]  = '{2'b00, 1, 0, 1,  0, 0,  0, 2, 3'b000};
    tbl[6]  = '{2'b10, 0, 0, 1,  1, 10, 0, 2, 3'b000};
    tbl[7]  = '{2'b10, 0, 0, 1,  1, 20, 0, 2, 3'b000};
    tbl[8]  = '{2'b10, 0, 0, 1,  1, 30, 0, 2, 3'b000};
    tbl[9]  = '{2'b00, 0, 0, 1,  2, 30, 6, 2, 3'b100};
    tbl[10] = '{2'b00, 1, 0, 1,  2, 30, 6, 2, 3'b000};
    tbl[11] = '{2'b01, 0, 0, 1,  2, 30, 6, 2, 3'b001};
    tbl[12] = '{2'b00, 0, 0, 17, 2, 30, 6, 2, 3'b000};
    tbl[13] = '{2'b00, 0, 0, 1,  0, 0,  0, 2, 3'b000};
    tbl[14] = '{2'b11, 0, 0, 1,  1, 5,  0, 2, 3'b001};
    tbl[15] = '{2'b10, 0, 1, 1,  3, 5,  5, 2, 3'b011};
    tbl[16] = '{2'b00, 0, 0, 19, 3, 5,  5, 2, 3'b000};
    tbl[17] = '{2'b00, 0, 0, 1,  0, 0,  0, 2, 3'b000};
    tbl[18] = '{2'b00, 1, 0, 1,  0, 0,  0, 3, 3'b000};
    tbl[19] = '{2'b00, 1, 0, 1,  0, 0,  0, 0, 3'b000};
    do_reset();
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].n; r++) cyc(tbl[k].c, tbl[k].s, tbl[k].x);
      chk($sformatf("vec%0d.state", k), state_o, tbl[k].st);
      chk($sformatf("vec%0d.credit", k), credit, tbl[k].cr);
      chk($sformatf("vec%0d.change", k), change, tbl[k].ch);
      chk($sformatf("vec%0d.item_idx", k), item_idx, tbl[k].idx);
      chk($sformatf("vec%0d.price", k), price, ptab[tbl[k].idx]);
      chk($sformatf("vec%0d.busy", k), busy, tbl[k].st >= 2);
      chk($sformatf("vec%0d.pulses", k), {vend_pulse, refund_pulse, reject_pulse}, tbl[k].p);
    end
    do_reset();
    repeat (3) cyc(0, 1, 0);
    cyc(2'b01, 0, 0);
    got = 0;
    for (int k = 1; k <= 60 && got == 0; k++) begin
      cyc(0, 0, 0);
      if (refund_pulse) got = k;
    end
    chk("timeout_cycles", got, TMO);
    chk("timeout_change", change, 5);
    do_reset();
    repeat (3) cyc(0, 1, 0);
    repeat (3) cyc(2'b10, 0, 0);
    cyc(0, 0, 0);
    chk("item3_vend_pulse", vend_pulse, 1);
    chk("item3_change", change, 0);
    cyc(0, 1, 0);
    chk("hold_sel_ignored", item_idx, 3);
    repeat (3) cyc(0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_credit", credit, 0);
    chk("async_rst_change", change, 0);
    chk("async_rst_idx", item_idx, 0);
    chk("async_rst_price", price, 5);
    m_reset();
    @(negedge clk) rst_n = 1;
    repeat (3) cyc(0, 1, 0);
    cyc(2'b10, 0, 0);
    cyc(0, 1, 0);
    chk("lower_price_state", state_o, 1);
    cyc(0, 0, 0);
    chk("lower_price_vend", vend_pulse, 1);
    chk("lower_price_change", change, 5);
    do_reset();
    repeat (3000) begin
      logic [1:0] c;
      logic s, x;
      c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s = ($urandom_range(0, 6) == 0);
      x = ($urandom_range(0, 19) == 0);
      cyc(c, s, x);
    end
    do_reset();
    repeat (12) drive2(2'b10, 0, 0);
    drive2(2'b01, 0, 0);
    chk("ovf_credit_125", credit2, 125);
    chk("ovf_no_reject", rj2, 0);
    drive2(2'b01, 0, 0);
    chk("ovf_coin0_credit", credit2, 125);
    chk("ovf_coin0_reject", rj2, 1);
    drive2(2'b10, 0, 0);
    chk("ovf_coin1_credit", credit2, 125);
    chk("ovf_coin1_reject", rj2, 1);
    repeat (100) drive2(0, 0, 0);
    chk("no_timeout_state", st2, 1);
    drive2(0, 0, 1);
    chk("ovf_refund_state", st2, 3);
    chk("ovf_refund_change", change2, 125);
    chk("ovf_refund_pulse", rp2, 1);
    repeat (3) drive2(0, 0, 0);
    chk("ovf_hold_busy", busy2, 1);
    drive2(0, 0, 0);
    chk("ovf_exit_state", st2, 0);
    chk("ovf_exit_credit", credit2, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
